serial_sub_n: RTL and testbench

//  Parametrised multi-bit subtractor built from chained 1-bit full-subtractor stages.

---
 rtl/serial_sub_n.sv | 149 ++++++++++++++
 tb/tb_serial_sub_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_n.sv
// Bit-serial subtractor: WIDTH-bit x - y - sub_in, BITS_PER_CYC bits per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_n #(
    parameter int WIDTH        = 8,
    parameter int BITS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             sub_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || BITS_PER_CYC < 1 || (WIDTH % BITS_PER_CYC) != 0) begin : g_bad_param
            $error("serial_sub_n: WIDTH must be >= 2 and a multiple of BITS_PER_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               sub_out_q, sub_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               a_bit;
    logic               b_bit;
    logic               bw;
    int                 base;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        sub_out_d = sub_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d     = ovf_q;
`endif
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bw        = borrow_q;
        base      = 0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    x_d      = x;
                    y_d      = y;
                    borrow_d = sub_in;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // Ripple the borrow through this cycle's chunk of full-subtractor stages.
                base = int'(cnt_q) * BITS_PER_CYC;
                for (int i = 0; i < BITS_PER_CYC; i++) begin
                    a_bit            = x_q[base + i];
                    b_bit            = y_q[base + i];
                    diff_d[base + i] = a_bit ^ b_bit ^ bw;
                    bw               = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
                end
                borrow_d  = bw;
                sub_out_d = bw;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != x_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            sub_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            sub_out_q <= sub_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign diff    = diff_q;
    assign sub_out = sub_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_n.sv
// Scoreboard bench for serial_sub_n: four instances (BITS_PER_CYC 1/2/4/8) share one stimulus
// stream; a transaction-level model predicts accepts, results and done timing per instance.
module tb_serial_sub_n;

    localparam int NI = 4;

    typedef struct {
        logic [7:0] diff;
        logic       so;
        logic       ovf;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       sub_in;

    logic       busy_a [NI];
    logic       done_a [NI];
    logic [7:0] diff_a [NI];
    logic       so_a   [NI];
    logic       ovf_a  [NI];

    int   n_tab [NI] = '{8, 4, 2, 1};
    int   rem   [NI];
    exp_t exp_q [NI][$];

    int   cyc        = 0;
    bit   mon_en     = 0;
    bit   post_rst   = 0;
    bit   final_req  = 0;
    bit   final_ack  = 0;
    int   compared   = 0;
    int   mismatched = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int BPC = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 8;
        serial_sub_n #(.WIDTH(8), .BITS_PER_CYC(BPC)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .x       (x),
            .y       (y),
            .sub_in  (sub_in),
            .busy    (busy_a[k]),
            .done    (done_a[k]),
            .diff    (diff_a[k]),
            .sub_out (so_a[k])
`ifdef SERIAL_SUB_OVF_EN
            ,
            .ovf     (ovf_a[k])
`endif
        );
`ifndef SERIAL_SUB_OVF_EN
        assign ovf_a[k] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Plain unsigned arithmetic: 9-bit subtraction, borrow is bit 8.
    function automatic exp_t refModel(logic [7:0] xv, logic [7:0] yv, logic si, int due);
        exp_t e;
        logic [8:0] r;
        r      = {1'b0, xv} - {1'b0, yv} - {8'd0, si};
        e.diff = r[7:0];
        e.so   = r[8];
        e.ovf  = (xv[7] != yv[7]) && (r[7] != xv[7]);
        e.due  = due;
        return e;
    endfunction

    // Transaction model: an instance accepts start whenever its previous op has finished.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                rem[k] = 0;
                exp_q[k].delete();
            end else if (rem[k] == 0) begin
                if (start) begin
                    exp_q[k].push_back(refModel(x, y, sub_in, cyc + n_tab[k]));
                    rem[k] = n_tab[k];
                end
            end else begin
                rem[k] = rem[k] - 1;
            end
        end
        post_rst = rst;
        if (rst) mon_en = 1'b1;
    end

    task automatic checkOutput(string name, int k, logic [15:0] got, logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s inst%0d cyc=%0d: got %0h want %0h", name, k, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                logic exp_done;
                exp_t e;
                exp_done = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
                checkOutput("busy", k, {15'd0, busy_a[k]}, {15'd0, rem[k] != 0});
                checkOutput("done", k, {15'd0, done_a[k]}, {15'd0, exp_done});
                if (exp_done) begin
                    e = exp_q[k].pop_front();
                    if (done_a[k]) begin
                        checkOutput("diff", k, {8'd0, diff_a[k]}, {8'd0, e.diff});
                        checkOutput("sub_out", k, {15'd0, so_a[k]}, {15'd0, e.so});
`ifdef SERIAL_SUB_OVF_EN
                        checkOutput("ovf", k, {15'd0, ovf_a[k]}, {15'd0, e.ovf});
`endif
                    end
                end
                if (post_rst) begin
                    checkOutput("rst_diff", k, {8'd0, diff_a[k]}, 16'd0);
                    checkOutput("rst_sub_out", k, {15'd0, so_a[k]}, 16'd0);
`ifdef SERIAL_SUB_OVF_EN
                    checkOutput("rst_ovf", k, {15'd0, ovf_a[k]}, 16'd0);
`endif
                end
            end
            if (final_req && !final_ack) begin
                for (int k = 0; k < NI; k++)
                    checkOutput("pending_ops", k, 16'(exp_q[k].size()), 16'd0);
                final_ack = 1'b1;
            end
        end
    end

    task automatic applyStimulus(logic [7:0] xv, logic [7:0] yv, logic si);
        @(negedge clk);
        x      = xv;
        y      = yv;
        sub_in = si;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitAllIdle();
        for (int t = 0; t < 20; t++) begin
            if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int gap;
        rst    = 1'b1;
        start  = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        sub_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h3C, 1'b0); waitAllIdle();
        applyStimulus(8'h00, 8'h01, 1'b0); waitAllIdle();
        applyStimulus(8'h00, 8'h00, 1'b1); waitAllIdle();
        applyStimulus(8'h80, 8'h01, 1'b0); waitAllIdle();
        applyStimulus(8'h7F, 8'hFF, 1'b0); waitAllIdle();
        applyStimulus(8'hFF, 8'h00, 1'b0); waitAllIdle();
        applyStimulus(8'h33, 8'h33, 1'b1); waitAllIdle();
        applyStimulus(8'hA5, 8'h5A, 1'b0); waitAllIdle();

        // Start held high across several ops: back-to-back accepts, operand churn mid-RUN.
        @(negedge clk);
        x = 8'hA5; y = 8'h5A; sub_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            x = 8'($urandom); y = 8'($urandom); sub_in = 1'($urandom);
        end
        start = 1'b0;
        waitAllIdle();

        // Second start pulse while the slower instances are still busy.
        applyStimulus(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        applyStimulus(8'hC3, 8'h3C, 1'b1);
        waitAllIdle();

        // Reset in the third RUN cycle aborts everything; then a fresh op.
        applyStimulus(8'h99, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h42, 8'h24, 1'b1);
        waitAllIdle();

        for (int op = 0; op < 200; op++) begin
            @(negedge clk);
            x = 8'($urandom); y = 8'($urandom); sub_in = 1'($urandom); start = 1'b1;
            gap = $urandom_range(0, 9);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                start = 1'b0;
                x = 8'($urandom); y = 8'($urandom); sub_in = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        waitAllIdle();
        repeat (3) @(negedge clk);

        final_req = 1'b1;
        for (int t = 0; t < 5 && !final_ack; t++) @(negedge clk);
        @(posedge clk);
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
